regbank_ctx_seq: RTL and testbench

- Context save/restore sequencer for the SH-1 general-purpose register bank (R0-R15).
- On request, it walks every register in index order. It copies each register to memory (save) or reloads each register from memory (restore), using one register-bank read port, the register-bank write port and a single-outstanding memory request port.
- It sits beside the decode/exception logic, which owns the register bank ports whenever `busy` is low.

---
 rtl/regbank_ctx_seq_if.sv | 17 +
 rtl/regbank_ctx_seq.sv | 129 ++++++++++++
 tb/tb_regbank_ctx_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_ctx_seq_if.sv
// Single-outstanding memory request port used by the register-bank context sequencer.
// The master issues req/we/addr/wdata; the slave answers with gnt and, for reads, rvalid/rdata.
interface regbank_ctx_seq_if #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [REG_WIDTH-1:0]  rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regbank_ctx_seq.sv
// Context save/restore sequencer: walks R0..R(REG_COUNT-1) in order, copying each register
// to memory (save) or reloading it from memory (restore) over a single-outstanding port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bank ports owned by decode/exception logic; waits for a start
// S_SAVE_REQ | memory write of R[idx] presented until granted
// S_RST_REQ  | memory read for R[idx] presented until granted
// S_RST_WAIT | read granted; waits for rvalid, then writes R[idx]
// S_DONE     | one-cycle completion pulse
module regbank_ctx_seq #(
  parameter  int REG_WIDTH  = 32,
  parameter  int REG_COUNT  = 16,
  parameter  int ADDR_WIDTH = 32,
  localparam int IDX_W      = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_save,
  input  logic                  start_restore,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      rb_raddr,
  input  logic [REG_WIDTH-1:0]  rb_rdata,
  output logic                  rb_we,
  output logic [IDX_W-1:0]      rb_waddr,
  output logic [REG_WIDTH-1:0]  rb_wdata,
  regbank_ctx_seq_if.master     mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_REQ,
    S_RST_REQ,
    S_RST_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] base;
  logic                  last;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign last     = (idx == IDX_W'(REG_COUNT - 1));
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign cur_addr = base + (ADDR_WIDTH'(idx) * ADDR_WIDTH'(REG_WIDTH / 8));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Save has priority; a coincident restore request is dropped.
          if (start_save) begin
            state <= S_SAVE_REQ;
            idx   <= '0;
            base  <= base_addr;
          end else if (start_restore) begin
            state <= S_RST_REQ;
            idx   <= '0;
            base  <= base_addr;
          end
        end
        S_SAVE_REQ: begin
          if (mem.gnt) begin
            if (last) state <= S_DONE;
            else      idx   <= idx + 1'b1;
          end
        end
        S_RST_REQ: begin
          if (mem.gnt) state <= S_RST_WAIT;
        end
        S_RST_WAIT: begin
          if (mem.rvalid) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_RST_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address/data outputs are forced to zero outside the states that own them.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    rb_raddr  = '0;
    rb_we     = 1'b0;
    rb_waddr  = '0;
    rb_wdata  = '0;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    case (state)
      S_SAVE_REQ: begin
        mem.req   = 1'b1;
        mem.we    = 1'b1;
        mem.addr  = cur_addr;
        rb_raddr  = idx;
        mem.wdata = rb_rdata;
      end
      S_RST_REQ: begin
        mem.req  = 1'b1;
        mem.addr = cur_addr;
      end
      S_RST_WAIT: begin
        if (mem.rvalid) begin
          rb_we    = 1'b1;
          rb_waddr = idx;
          rb_wdata = mem.rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regbank_ctx_seq.sv
// Self-checking bench for regbank_ctx_seq: transfer-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regbank_ctx_seq;
  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_save = 1'b0;
  logic        start_restore = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, rb_we;
  logic [3:0]  rb_raddr, rb_waddr;
  logic [31:0] rb_rdata, rb_wdata;

  logic [31:0] bank  [RC];   // bank contents seen by the save path (bench main writes)
  logic [31:0] rbank [RC];   // bank contents written by restores (responder writes)
  logic [31:0] rimg  [RC];   // memory image served to restores
  logic [31:0] rbase = 32'h2000;

  regbank_ctx_seq_if #(.REG_WIDTH(32), .ADDR_WIDTH(32)) mem ();

  regbank_ctx_seq #(.REG_WIDTH(32), .REG_COUNT(RC), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done), .rb_raddr(rb_raddr),
    .rb_rdata(rb_rdata), .rb_we(rb_we), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
    .mem(mem)
  );

  always #5 clk = ~clk;
  assign rb_rdata = bank[rb_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory / bank responder ----------------
  int rv_delay = 1, rd_cnt = 0, n_gnt = 0, stall_at = -1, stall_used = 0, rd_req_cnt = 0;
  logic [31:0] rd_a;
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [3:0]  rbw_addr_q[$];

  initial begin
    mem.gnt = 1'b1; mem.rvalid = 1'b0; mem.rdata = '0;
    forever begin
      logic f, w, rbw;
      logic [31:0] a, d, rwd;
      logic [3:0] rwa;
      @(negedge clk);
      f = mem.req && mem.gnt; w = mem.we; a = mem.addr; d = mem.wdata;
      rbw = rb_we; rwa = rb_waddr; rwd = rb_wdata;
      @(posedge clk); #1;
      mem.rvalid = 1'b0;
      if (!rst_n) begin
        rd_cnt = 0;
      end else begin
        if (rbw) begin rbank[rwa] = rwd; rbw_addr_q.push_back(rwa); end
        if (f) begin
          n_gnt++; stall_used = 0;
          if (w) begin wr_addr_q.push_back(a); wr_data_q.push_back(d); end
          else begin rd_req_cnt++; rd_a = a; rd_cnt = rv_delay; end
        end
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            mem.rvalid = 1'b1;
            mem.rdata  = rimg[4'((rd_a - rbase) >> 2)];
          end
        end
        if (stall_at == n_gnt && stall_used < 3) begin mem.gnt = 1'b0; stall_used++; end
        else mem.gnt = 1'b1;
      end
    end
  end

  // ---------------- transfer-level model + per-cycle compare ----------------
  int m_kind = 0;           // 0 none, 1 save, 2 restore
  int m_k = 0;              // registers completed so far
  bit m_out = 0;            // restore read granted, data pending
  bit m_done = 0;
  logic [31:0] m_base = '0;
  int cyc = 0, busy_total = 0, done_cyc = 0, last_we_cyc = 0, start_cyc = 0, probe_cnt = 0;
  logic [31:0] probe_addr = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    bit act, e_req, e_we, e_rbwe;
    cyc++;
    if (!rst_n) begin m_kind = 0; m_k = 0; m_out = 0; m_done = 0; m_base = '0; end
    act    = (m_kind != 0);
    e_req  = act && !m_out;
    e_we   = e_req && (m_kind == 1);
    e_rbwe = (m_kind == 2) && m_out && mem.rvalid;
    chk("busy", busy, act || m_done);
    chk("done", done, m_done);
    chk("mem_req", mem.req, e_req);
    chk("rb_we", rb_we, e_rbwe);
    chk("rb_raddr", rb_raddr, e_we ? 32'(m_k) : 32'd0);
    if (e_req || !rst_n) begin
      chk("mem_we", mem.we, e_we);
      chk("mem_addr", mem.addr, e_req ? m_base + 32'(4 * m_k) : 32'd0);
      chk("mem_wdata", mem.wdata, e_we ? bank[m_k] : 32'd0);
    end
    if (e_rbwe || !rst_n) begin
      chk("rb_waddr", rb_waddr, e_rbwe ? 32'(m_k) : 32'd0);
      chk("rb_wdata", rb_wdata, e_rbwe ? mem.rdata : 32'd0);
    end
    if (busy) busy_total++;
    if (done) done_cyc = cyc;
    if (rb_we) last_we_cyc = cyc;
    if (mem.req && mem.addr == probe_addr) probe_cnt++;
    if (rst_n) begin
      if (m_done) m_done = 0;
      else if (!act) begin
        if (start_save || start_restore) begin
          m_kind = start_save ? 1 : 2; m_k = 0; m_out = 0; m_base = base_addr; start_cyc = cyc;
        end
      end else if (m_kind == 1) begin
        if (mem.gnt) begin m_k++; if (m_k == RC) begin m_kind = 0; m_done = 1; end end
      end else if (!m_out) begin
        if (mem.gnt) m_out = 1;
      end else if (mem.rvalid) begin
        m_out = 0; m_k++;
        if (m_k == RC) begin m_kind = 0; m_done = 1; end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic do_start(input bit s, input bit r, input logic [31:0] a);
    @(posedge clk); #1;
    start_save = s; start_restore = r; base_addr = a;
    @(posedge clk); #1;
    start_save = 1'b0; start_restore = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done) begin got = 1; break; end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin
    int wb, bt, pc, rc, rb0;
    bit ok, found;
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, bt, pc, rc, rb0;
    bit ok, found;
    for (int k = 0; k < RC; k++) begin bank[k] = 32'hA0 + k; rimg[k] = 32'h5500 + k; rbank[k] = '0; end

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", mem.req, 0);
    chk("reset_mem_addr", mem.addr, 0);
    chk("reset_rb_we", rb_we, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: plain save
    wb = wr_addr_q.size(); bt = busy_total;
    do_start(1, 0, 32'h1000);
    wait_done(60, "t1_done_timeout");
    chk("t1_nwrites", wr_addr_q.size() - wb, 16);
    chk("t1_addr0", wr_addr_q[wb], 32'h1000);
    chk("t1_addr15", wr_addr_q[wb + 15], 32'h103C);
    chk("t1_data0", wr_data_q[wb], 32'hA0);
    chk("t1_data15", wr_data_q[wb + 15], 32'hAF);
    chk("t1_done_latency", done_cyc - start_cyc, 17);
    chk("t1_busy_cycles", busy_total - bt, 17);

    // 2: save with a 3-cycle grant stall on R5
    wb = wr_addr_q.size(); pc = probe_cnt;
    probe_addr = 32'h1014; stall_at = n_gnt + 5;
    do_start(1, 0, 32'h1000);
    wait_done(60, "t2_done_timeout");
    stall_at = -1; probe_addr = 32'hFFFF_FFFF;
    chk("t2_r5_held_cycles", probe_cnt - pc, 4);
    chk("t2_nwrites", wr_addr_q.size() - wb, 16);
    ok = 1;
    for (int k = 0; k < RC; k++)
      if (wr_addr_q[wb + k] !== 32'h1000 + 4 * k || wr_data_q[wb + k] !== 32'hA0 + k) ok = 0;
    chk("t2_sequence", 32'(ok), 1);

    // 3: restore, rvalid two cycles after each grant
    rv_delay = 2; rb0 = rbw_addr_q.size();
    do_start(0, 1, 32'h2000);
    wait_done(120, "t3_done_timeout");
    chk("t3_nrbwrites", rbw_addr_q.size() - rb0, 16);
    ok = 1;
    for (int k = 0; k < RC; k++)
      if (rbank[k] !== 32'h5500 + k || rbw_addr_q[rb0 + k] !== 4'(k)) ok = 0;
    chk("t3_bank_contents", 32'(ok), 1);
    chk("t3_done_latency", done_cyc - start_cyc, 49);
    chk("t3_done_after_r15", done_cyc - last_we_cyc, 1);
    rv_delay = 1;

    // 4: simultaneous starts, restore pulses mid-save and during DONE
    wb = wr_addr_q.size(); rc = rd_req_cnt;
    do_start(1, 1, 32'h1000);
    repeat (5) @(posedge clk);
    #1 start_restore = 1'b1;
    @(posedge clk); #1 start_restore = 1'b0;
    wait_done(60, "t4_done_timeout");
    start_restore = 1'b1;
    @(posedge clk); #1 start_restore = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_idle_after", busy, 0);
    chk("t4_nwrites", wr_addr_q.size() - wb, 16);
    chk("t4_no_reads", rd_req_cnt - rc, 0);

    // 5: address wrap
    wb = wr_addr_q.size();
    do_start(1, 0, 32'hFFFF_FFF8);
    wait_done(60, "t5_done_timeout");
    chk("t5_addr0", wr_addr_q[wb], 32'hFFFF_FFF8);
    chk("t5_addr1", wr_addr_q[wb + 1], 32'hFFFF_FFFC);
    chk("t5_addr2", wr_addr_q[wb + 2], 32'h0);
    chk("t5_addr15", wr_addr_q[wb + 15], 32'h34);

    // 6: reset while writing R7 during restore
    for (int k = 0; k < RC; k++) rimg[k] = 32'h7700 + k;
    rb0 = rbw_addr_q.size();
    do_start(0, 1, 32'h2000);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (rb_we && rb_waddr == 4'd7) begin found = 1; break; end
    end
    chk("t6_reach_r7", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rb_we_off", rb_we, 0);
    chk("t6_mem_req_off", mem.req, 0);
    chk("t6_busy_off", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_reset", busy, 0);
    chk("t6_r7_not_written", rbw_addr_q.size() - rb0, 7);
    wb = wr_addr_q.size();
    do_start(1, 0, 32'h3000);
    wait_done(60, "t6_done_timeout");
    chk("t6_restart_addr0", wr_addr_q[wb], 32'h3000);
    chk("t6_restart_nwrites", wr_addr_q.size() - wb, 16);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
